// File: rtl/clk_div_bank.sv
// Bank of independent integer clock dividers with glitch-free divisor reload
// applied at each channel's period boundary and a global phase-realign input.
module clk_div_bank #(
    parameter int unsigned          NCH      = 3,
    parameter int unsigned          CNT_W    = 16,
    parameter logic [NCH*CNT_W-1:0] DIV_INIT = {16'd10080, 16'd252, 16'd126}
) (
    input  logic             clk80,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic             div_load,
    input  logic [3:0]       div_sel,
    input  logic [CNT_W-1:0] div_data,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   rise_stb,
    output logic [NCH-1:0]   wrap_stb,
    output logic [NCH-1:0]   pend
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam logic [CNT_W-1:0] INIT = DIV_INIT[g*CNT_W +: CNT_W];

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] pdiv_q, pdiv_d;
        logic             clk_q, clk_d;
        logic             rise_q, rise_d;
        logic             wrap_q, wrap_d;
        logic             pend_q, pend_d;
        logic [CNT_W-1:0] ne, lo_len, cnt_n;
        logic             at_end, hit, wrapping;

        always_comb begin
            ne       = (div_q < CNT_W'(2)) ? CNT_W'(2) : div_q;
            lo_len   = ne - (ne >> 1);
            at_end   = (cnt_q == ne - 1'b1);
            cnt_n    = at_end ? '0 : cnt_q + 1'b1;
            hit      = div_load && (div_sel == 4'(g));
            wrapping = en[g] && at_end;

            cnt_d  = cnt_q;
            clk_d  = clk_q;
            rise_d = 1'b0;
            wrap_d = 1'b0;
            div_d  = div_q;
            pdiv_d = pdiv_q;
            pend_d = pend_q;

            if (sync) begin
                cnt_d  = '0;
                clk_d  = 1'b0;
                div_d  = hit ? div_data : pdiv_q;
                pdiv_d = div_d;
                pend_d = 1'b0;
            end else begin
                if (en[g]) begin
                    cnt_d  = cnt_n;
                    clk_d  = (cnt_n >= lo_len);
                    rise_d = (cnt_n == lo_len);
                    wrap_d = at_end;
                end
                // A load landing on the wrap edge bypasses the pending register
                if (hit) begin
                    pdiv_d = div_data;
                    if (wrapping) begin
                        div_d  = div_data;
                        pend_d = 1'b0;
                    end else begin
                        pend_d = 1'b1;
                    end
                end else if (wrapping) begin
                    div_d  = pdiv_q;
                    pend_d = 1'b0;
                end
            end
        end

        always_ff @(posedge clk80 or negedge reset) begin
            if (!reset) begin
                cnt_q  <= '0;
                div_q  <= INIT;
                pdiv_q <= INIT;
                clk_q  <= 1'b0;
                rise_q <= 1'b0;
                wrap_q <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                pdiv_q <= pdiv_d;
                clk_q  <= clk_d;
                rise_q <= rise_d;
                wrap_q <= wrap_d;
                pend_q <= pend_d;
            end
        end

        assign clk_out[g]  = clk_q;
        assign rise_stb[g] = rise_q;
        assign wrap_stb[g] = wrap_q;
        assign pend[g]     = pend_q;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Lockstep check of clk_div_bank against a period/phase model, plus period,
// duty and sync-alignment measurements against fixed expectations.
`timescale 1ns/1ps
module tb_clk_div_bank;
    localparam int unsigned NCH   = 3;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned INIT [NCH] = '{126, 252, 10080};

    logic             clk80    = 1'b0;
    logic             reset    = 1'b0;
    logic [NCH-1:0]   en       = '0;
    logic             sync     = 1'b0;
    logic             div_load = 1'b0;
    logic [3:0]       div_sel  = '0;
    logic [CNT_W-1:0] div_data = '0;
    logic [NCH-1:0]   clk_out, rise_stb, wrap_stb, pend;

    always #6 clk80 = ~clk80;

    clk_div_bank #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk80    (clk80),
        .reset    (reset),
        .en       (en),
        .sync     (sync),
        .div_load (div_load),
        .div_sel  (div_sel),
        .div_data (div_data),
        .clk_out  (clk_out),
        .rise_stb (rise_stb),
        .wrap_stb (wrap_stb),
        .pend     (pend)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: position within the period, active/pending divisor
    int unsigned    m_pos  [NCH];
    int unsigned    m_div  [NCH];
    int unsigned    m_pdiv [NCH];
    logic [NCH-1:0] m_clk, m_rise, m_wrap, m_pend;

    // Measurements taken from the DUT outputs
    int unsigned cyc_n = 0;
    int unsigned ref_cyc = 0;
    int unsigned last_rise  [NCH];
    int unsigned rise_gap   [NCH];
    int unsigned hi_cnt     [NCH];
    int unsigned hi_len     [NCH];
    int unsigned first_rise [NCH];

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_pos[ch]  = 0;
            m_div[ch]  = INIT[ch];
            m_pdiv[ch] = INIT[ch];
        end
        m_clk = '0; m_rise = '0; m_wrap = '0; m_pend = '0;
    endtask

    task automatic meas_reset();
        ref_cyc = cyc_n;
        for (int ch = 0; ch < NCH; ch++) begin
            last_rise[ch] = cyc_n; rise_gap[ch] = 0; hi_cnt[ch] = 0;
            hi_len[ch] = 0; first_rise[ch] = 0;
        end
    endtask

    task automatic model_step();
        for (int ch = 0; ch < NCH; ch++) begin
            int unsigned ne, lo;
            bit hit, wrapping;
            ne  = (m_div[ch] < 2) ? 2 : m_div[ch];
            lo  = (ne + 1) / 2;
            hit = div_load && (int'(div_sel) == ch);
            if (sync) begin
                m_pos[ch]  = 0;
                m_clk[ch]  = 1'b0; m_rise[ch] = 1'b0; m_wrap[ch] = 1'b0;
                m_div[ch]  = hit ? int'(div_data) : m_pdiv[ch];
                m_pdiv[ch] = m_div[ch];
                m_pend[ch] = 1'b0;
            end else begin
                wrapping = en[ch] && (m_pos[ch] + 1 == ne);
                if (en[ch]) begin
                    m_pos[ch]  = (m_pos[ch] + 1) % ne;
                    m_clk[ch]  = (m_pos[ch] >= lo);
                    m_rise[ch] = (m_pos[ch] == lo);
                    m_wrap[ch] = (m_pos[ch] == 0);
                end else begin
                    m_rise[ch] = 1'b0; m_wrap[ch] = 1'b0;
                end
                if (hit) begin
                    m_pdiv[ch] = int'(div_data);
                    if (wrapping) begin m_div[ch] = int'(div_data); m_pend[ch] = 1'b0; end
                    else m_pend[ch] = 1'b1;
                end else if (wrapping) begin
                    m_div[ch]  = m_pdiv[ch];
                    m_pend[ch] = 1'b0;
                end
            end
        end
    endtask

    task automatic cyc();
        bit was_sync;
        was_sync = sync;
        @(posedge clk80);
        model_step();
        #1;
        check("clk_out",  32'(clk_out),  32'(m_clk));
        check("rise_stb", 32'(rise_stb), 32'(m_rise));
        check("wrap_stb", 32'(wrap_stb), 32'(m_wrap));
        check("pend",     32'(pend),     32'(m_pend));
        cyc_n++;
        if (was_sync) begin
            ref_cyc = cyc_n;
            for (int ch = 0; ch < NCH; ch++) first_rise[ch] = 0;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (rise_stb[ch]) begin
                rise_gap[ch]  = cyc_n - last_rise[ch];
                last_rise[ch] = cyc_n;
                if (first_rise[ch] == 0) first_rise[ch] = cyc_n - ref_cyc;
            end
            if (clk_out[ch]) hi_cnt[ch]++;
            else begin
                if (hi_cnt[ch] != 0) hi_len[ch] = hi_cnt[ch];
                hi_cnt[ch] = 0;
            end
        end
        div_load = 1'b0;
        sync     = 1'b0;
    endtask

    task automatic run(input int unsigned n);
        repeat (n) cyc();
    endtask

    task automatic load(input int unsigned sel, input int unsigned data);
        div_load = 1'b1;
        div_sel  = 4'(sel);
        div_data = CNT_W'(data);
        cyc();
    endtask

    task automatic wait_rise(input int unsigned ch, input int unsigned budget, input string tag);
        bit seen = 1'b0;
        for (int unsigned k = 0; k < budget && !seen; k++) begin
            cyc();
            seen = rise_stb[ch];
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_clk"},  32'(clk_out),  32'd0);
        check({tag, "_rise"}, 32'(rise_stb), 32'd0);
        check({tag, "_wrap"}, 32'(wrap_stb), 32'd0);
        check({tag, "_pend"}, 32'(pend),     32'd0);
    endtask

    initial begin
        model_reset();
        #20;
        check_zero("rst");
        @(negedge clk80);
        reset = 1'b1;
        en    = '1;
        meas_reset();

        run(15200);
        check("p_ch0", rise_gap[0], 32'd126);
        check("p_ch1", rise_gap[1], 32'd252);
        check("p_ch2", rise_gap[2], 32'd10080);
        check("hi_ch0", hi_len[0], 32'd63);
        check("hi_ch1", hi_len[1], 32'd126);
        check("hi_ch2", hi_len[2], 32'd5040);
        check("first_ch0", first_rise[0], 32'd63);
        check("first_ch2", first_rise[2], 32'd5040);

        wait_rise(0, 200, "wait_ch0");
        run(10);
        load(0, 7);
        check("pend0_set", 32'(pend[0]), 32'd1);
        run(20);
        check("pend0_hold", 32'(pend[0]), 32'd1);
        run(200);
        check("pend0_clr", 32'(pend[0]), 32'd0);
        check("p7_ch0", rise_gap[0], 32'd7);
        check("hi7_ch0", hi_len[0], 32'd3);

        load(1, 0);
        run(600);
        check("p0_ch1", rise_gap[1], 32'd2);
        check("hi0_ch1", hi_len[1], 32'd1);
        load(1, 1);
        run(20);
        check("p1_ch1", rise_gap[1], 32'd2);
        load(5, 99);
        check("sel5_pend", 32'(pend), 32'd0);
        run(20);
        load(1, 252);
        run(600);

        load(0, 126);
        run(2);
        sync = 1'b1;
        cyc();
        check("sync_clk", 32'(clk_out), 32'd0);
        check("sync_pend", 32'(pend), 32'd0);
        run(5100);
        check("sync_first0", first_rise[0], 32'd63);
        check("sync_first1", first_rise[1], 32'd126);
        check("sync_first2", first_rise[2], 32'd5040);

        sync     = 1'b1;
        div_load = 1'b1;
        div_sel  = 4'd0;
        div_data = CNT_W'(9);
        cyc();
        run(50);
        check("syncload_p0", rise_gap[0], 32'd9);

        wait_rise(1, 300, "wait_ch1");
        run(20);
        en[1] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            check("en_hold_clk", 32'(clk_out[1]), 32'd1);
            check("en_hold_rise", 32'(rise_stb[1]), 32'd0);
        end
        en = '1;
        run(240);
        check("en_p_ch1", rise_gap[1], 32'd292);

        load(2, 50);
        run(5);
        check("ch2_pend", 32'(pend[2]), 32'd1);
        @(posedge clk80);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_zero("midrst");
        @(negedge clk80);
        reset = 1'b1;
        meas_reset();
        run(15200);
        check("rst_p_ch2", rise_gap[2], 32'd10080);
        check("rst_first2", first_rise[2], 32'd5040);
        check("rst_p_ch0", rise_gap[0], 32'd126);

        for (int k = 0; k < 3000; k++) begin
            en = NCH'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                div_load = 1'b1;
                div_sel  = 4'($urandom_range(0, 5));
                div_data = CNT_W'($urandom_range(0, 24));
            end
            if ($urandom_range(0, 299) == 0) sync = 1'b1;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised bank of NCH independent integer clock dividers, all running from the 80.640 MHz system clock.
- Each channel produces a divided clock with near-50% duty, a one-cycle rising-edge strobe, and a one-cycle period-start strobe.
- Divisors are reloadable at run time and take effect glitch-free at the channel's period boundary.
- A global sync input realigns all channels; the bank feeds frame/bit timing (640 kHz, 320 kHz, 8 kHz by default).

Parameters:
- NCH, 3, number of divider channels (1..16)
- CNT_W, 16, counter/divisor width in bits
- DIV_INIT, {16'd10080,16'd252,16'd126}, flattened NCH*CNT_W reset divisors; channel 0 in LSBs (126→640 kHz, 252→320 kHz, 10080→8 kHz)

Ports:
- clk80  input  1  system clock, 80.640 MHz, rising edge
- reset  input  1  asynchronous active-low reset
- en  input  NCH  per-channel count enable; low freezes counter and outputs
- sync  input  1  synchronous realign of all channels
- div_load  input  1  one-cycle write strobe for a new divisor
- div_sel  input  4  target channel index for div_load
- div_data  input  CNT_W  new divisor value
- clk_out  output  NCH  divided clocks, registered
- rise_stb  output  NCH  one-cycle pulse coincident with clk_out 0→1
- wrap_stb  output  NCH  one-cycle pulse when the counter returns to 0
- pend  output  NCH  high while a loaded divisor is waiting for its wrap

Behaviour:
- Reset (reset=0, asynchronous):
  - cnt=0, clk_out=0, rise_stb=0, wrap_stb=0, pend=0.
  - Active divisor N = DIV_INIT slice; pending register = DIV_INIT slice.
- Effective divisor Ne = max(N,2).
  - Low length L = Ne - floor(Ne/2), i.e. ceil(Ne/2); high length = floor(Ne/2).
  - Odd Ne gives the extra cycle in the low phase.
- Per channel, each clk80 edge with en=1 and sync=0:
  - cnt_n = (cnt==Ne-1) ? 0 : cnt+1; cnt<=cnt_n.
  - clk_out <= (cnt_n >= L).
  - rise_stb <= (cnt_n == L).
  - wrap_stb <= (cnt_n == 0).
  - Period is exactly Ne cycles; clk_out is low for L cycles then high for Ne-L cycles.
- en=0: cnt and clk_out hold; rise_stb and wrap_stb forced 0 on that edge. Resuming continues from the held count with no extra edges.
- sync=1 (overrides en and load application):
  - All channels: cnt<=0, clk_out<=0, rise_stb<=0, wrap_stb<=0.
  - Any pending divisor becomes active immediately; pend<=0.
  - After sync deasserts, every channel begins a fresh period in phase.
- Divisor load, when div_load=1 and div_sel<NCH:
  - Pending register of channel div_sel <= div_data; pend[div_sel]<=1.
  - div_sel>=NCH: write ignored, no state change.
- Divisor apply:
  - On the edge where the channel wraps (cnt==Ne-1, en=1), active N <= pending, pend<=0.
  - The new divisor governs cnt_n and clk_out from that wrap onward. The period in progress always completes with the old divisor, so there are no runt pulses.
  - If div_load targets a channel on the same edge it wraps, the new div_data is applied at that wrap (bypass) and pend stays 0.
  - If div_load and sync occur on the same edge, div_data becomes active directly.
  - A second load before the wrap overwrites the pending value; only the last value is applied.
- Divisor 0 or 1: behaves as divisor 2 (clk_out toggles every cycle, 40.32 MHz).
- Width rules: cnt and N are CNT_W bits unsigned; comparisons are unsigned; no overflow since cnt<Ne≤2^CNT_W-1.
- Reset asserted mid-period: immediate return to reset values; a pending load is lost and the DIV_INIT value is restored.
- Latency: clk_out, rise_stb and wrap_stb are registered, updated on the same edge as cnt; zero added latency relative to the counter.

Test Plan:
- Release reset, en=all 1 → ch0 period 126 cycles (63 low/63 high), ch1 252 (126/126), ch2 10080 (5040/5040); rise_stb and wrap_stb each pulse once per period, one cycle wide.
- Load div_sel=0, div_data=7 mid-period → pend[0]=1 until the current 126-cycle period ends; then period 7 (4 low/3 high); no runt pulse.
- div_data=0 and div_data=1 on ch1 → after wrap, clk_out[1] toggles every cycle; div_sel=5 with NCH=3 → no channel changes.
- Pulse sync for 1 cycle at an arbitrary point → all cnt=0, clk_out=0; first rise_stb at cycle 63 (ch0), 126 (ch1), 5040 (ch2) after sync; a pending load is applied immediately.
- en[1]=0 for 40 cycles mid-high phase → clk_out[1] holds 1, no strobes; the remainder of the period completes after re-enable, making the period 292 cycles.
- Assert reset during a pending load on ch2 → outputs 0, pend=0; after release ch2 divides by 10080.
